// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin arbiter that lets NUM_REQ requesters share one
// external count-down timer. The winner's delay is latched, the timer is
// cleared/loaded for one cycle, enabled until it stops reporting a pending
// delay, and the owner then receives a one-cycle done pulse.
module timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_value,
  input  logic [NUM_REQ-1:0]       cancel,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [WIDTH-1:0]         remaining,
  output logic                     timer_rst,
  output logic                     timer_enable,
  output logic                     timer_mode,
  output logic                     timer_count_once,
  output logic [WIDTH-1:0]         timer_count_down_value,
  input  logic [WIDTH-1:0]         timer_counter,
  input  logic                     timer_delay_pending
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] win_value;
  logic             win_found;
  logic [IW-1:0]    owner_inc;
  int unsigned      scan_k;

  // Round-robin search: first set request at or after the rotation pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_k    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_k = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req[IW'(scan_k)]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_k);
      end
    end
  end

  // Delay slice of the current winner.
  always_comb begin
    win_value = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_value = req_value[i*WIDTH +: WIDTH];
      end
    end
  end

  assign owner_inc = IW'((32'(owner_q) + 1) % NUM_REQ);

  // State, owner, rotation pointer and latched delay registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      value_q <= value_d;
    end
  end

  // Next-state logic and timer/requester outputs.
  always_comb begin
    state_d                = state_q;
    owner_d                = owner_q;
    ptr_d                  = ptr_q;
    value_d                = value_q;
    grant                  = '0;
    done                   = '0;
    busy                   = 1'b1;
    remaining              = '0;
    timer_rst              = 1'b0;
    timer_enable           = 1'b0;
    timer_mode             = 1'b1;
    timer_count_once       = 1'b0;
    timer_count_down_value = value_q;
    unique case (state_q)
      IDLE: begin
        busy                   = 1'b0;
        timer_rst              = 1'b1;
        timer_count_down_value = '0;
        if (win_found) begin
          state_d = LOAD;
          owner_d = win_idx;
          value_d = win_value;
        end
      end
      LOAD: begin
        grant     = NUM_REQ'(1) << owner_q;
        timer_rst = 1'b1;
        if (cancel[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        grant        = NUM_REQ'(1) << owner_q;
        timer_enable = 1'b1;
        remaining    = timer_counter;
        // Cancel takes priority over a simultaneous completion.
        if (cancel[owner_q]) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else if (!timer_delay_pending) begin
          state_d = DONE;
        end
      end
      DONE: begin
        grant   = NUM_REQ'(1) << owner_q;
        done    = NUM_REQ'(1) << owner_q;
        state_d = IDLE;
        ptr_d   = owner_inc;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: models the external count-down timer, queues the
// expected owner and cycle of every done pulse, and a monitor pops the queue
// whenever the DUT raises done.
module tb_timer_scheduler;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_value;
  logic [N-1:0]   cancel;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   remaining;
  logic           timer_rst;
  logic           timer_enable;
  logic           timer_mode;
  logic           timer_count_once;
  logic [W-1:0]   timer_count_down_value;
  logic [W-1:0]   tcnt = '0;
  logic           pending;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;
  exp_t     exp_q[$];
  exp_t     e;
  logic [N-1:0] onehot;

  timer_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req                    (req),
    .req_value              (req_value),
    .cancel                 (cancel),
    .grant                  (grant),
    .done                   (done),
    .busy                   (busy),
    .remaining              (remaining),
    .timer_rst              (timer_rst),
    .timer_enable           (timer_enable),
    .timer_mode             (timer_mode),
    .timer_count_once       (timer_count_once),
    .timer_count_down_value (timer_count_down_value),
    .timer_counter          (tcnt),
    .timer_delay_pending    (pending)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count-down timer model: reset loads the delay, enable decrements to zero.
  always @(posedge clk) begin
    if (timer_rst) tcnt <= timer_count_down_value;
    else if (timer_enable && tcnt != 0) tcnt <= tcnt - 1;
  end
  assign pending = (tcnt != 0);

  // Monitor: every done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (cyc > 2 && done !== '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done actual=%b required=0000 cycle=%0d", done, cyc);
      end else begin
        e = exp_q.pop_front();
        onehot = N'(1) << e.idx;
        if (done !== onehot || grant !== onehot || cyc != e.cyc) begin
          failures++;
          $display("FAIL done_pulse actual done=%b grant=%b cycle=%0d required done=%b cycle=%0d",
                   done, grant, cyc, onehot, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'h0);
    chk({tag, "_done"}, 64'(done), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_remaining"}, remaining, 64'h0);
    chk({tag, "_tmr_en"}, 64'(timer_enable), 64'h0);
    chk({tag, "_tmr_rst"}, 64'(timer_rst), 64'h1);
    chk({tag, "_tmr_cdv"}, timer_count_down_value, 64'h0);
    chk({tag, "_tmr_mode"}, 64'(timer_mode), 64'h1);
    chk({tag, "_tmr_once"}, 64'(timer_count_once), 64'h0);
  endtask

  task automatic expect_done(input int idx, input int at);
    exp_q.push_back('{idx: idx, cyc: at});
  endtask

  // Wait (bounded) for done[idx], then drop that requester's req.
  task automatic wait_done(input int idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done[idx] !== 1'b1 && n < 400);
    chk($sformatf("wait_done%0d", idx), 64'(done[idx]), 64'h1);
    req[idx] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; cancel = '0; req_value = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single request, delay 50: done during cycle E0+52.
    req_value[0*W +: W] = 64'd50; req[0] = 1'b1;
    expect_done(0, cyc + 53);
    @(negedge clk);
    chk("single_grant", 64'(grant), 64'h1);
    chk("single_load_rst", 64'(timer_rst), 64'h1);
    chk("single_load_cdv", timer_count_down_value, 64'd50);
    req_value[0*W +: W] = 64'd7;
    @(negedge clk);
    chk("single_run_en", 64'(timer_enable), 64'h1);
    chk("single_run_rem0", remaining, 64'd50);
    repeat (10) @(negedge clk);
    chk("single_rem40", remaining, 64'd40);
    chk("single_cdv_held", timer_count_down_value, 64'd50);
    wait_done(0);
    @(negedge clk);
    @(negedge clk);
    chk("single_busy_after", 64'(busy), 64'h0);

    // Contention from reset: owners 0,1,2,3, nine cycles apart.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) req_value[i*W +: W] = 64'd5;
    req = 4'hF;
    for (int k = 0; k < N; k++) expect_done(k, cyc + 8 + 9 * k);
    @(negedge clk);
    chk("cont_grant0", 64'(grant), 64'h1);
    for (int k = 0; k < N; k++) wait_done(k);
    @(negedge clk);

    // Rotation: owner 2 alone, then 0101 -> 0 wins (search wraps from 3).
    req_value[2*W +: W] = 64'd3; req = 4'b0100;
    expect_done(2, cyc + 6);
    wait_done(2);
    @(negedge clk);
    req_value[0*W +: W] = 64'd2; req_value[2*W +: W] = 64'd4; req = 4'b0101;
    expect_done(0, cyc + 5);
    expect_done(2, cyc + 13);
    @(negedge clk);
    chk("rot_grant", 64'(grant), 64'h1);
    wait_done(0);
    wait_done(2);
    @(negedge clk);

    // Cancel: requester 1, delay 100, cancelled 20 cycles into RUN.
    req_value[1*W +: W] = 64'd100; req = 4'b0010;
    @(negedge clk);
    chk("cancel_grant", 64'(grant), 64'h2);
    @(negedge clk);
    chk("cancel_rem100", remaining, 64'd100);
    cancel[0] = 1'b1;
    @(negedge clk);
    chk("cancel_nonowner_busy", 64'(busy), 64'h1);
    chk("cancel_nonowner_grant", 64'(grant), 64'h2);
    cancel[0] = 1'b0;
    repeat (18) @(negedge clk);
    chk("cancel_rem81", remaining, 64'd81);
    cancel[1] = 1'b1; req[1] = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 64'(busy), 64'h0);
    chk("cancel_grant_off", 64'(grant), 64'h0);
    chk("cancel_tmr_en", 64'(timer_enable), 64'h0);
    cancel = '0;
    @(negedge clk);

    // Zero delay: done during cycle E0+2.
    req_value[3*W +: W] = 64'd0; req = 4'b1000;
    expect_done(3, cyc + 3);
    wait_done(3);
    @(negedge clk);

    // Reset ten cycles into RUN aborts without done.
    req_value[0*W +: W] = 64'd50; req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    repeat (9) @(negedge clk);
    chk("midrst_rem41", remaining, 64'd41);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk_reset("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Pointer back at 0 after reset: 1010 -> requester 1 first.
    req_value[1*W +: W] = 64'd0; req_value[3*W +: W] = 64'd9; req = 4'b1010;
    expect_done(1, cyc + 3);
    @(negedge clk);
    chk("postrst_grant", 64'(grant), 64'h2);
    wait_done(1);
    req = '0;
    repeat (6) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
